// File: rtl/rs_hs_pkg.sv
// Shared definitions for the relay-station handshake pipeline: storage padding,
// memory style selector and sizing helpers.
package rs_hs_pkg;

  localparam int REAL_DEPTH_PAD = 4;

  typedef enum logic [1:0] {
    MEM_REG   = 2'd0,
    MEM_DIST  = 2'd1,
    MEM_BLOCK = 2'd2
  } mem_style_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Beats that can still land at the tail after ready deasserts at the tail.
  function automatic int grace_period(input int body_level, input bit ready_in_head,
                                      input bit valid_in_head, input int extra_before_tail);
    return body_level + int'(ready_in_head) + int'(valid_in_head) + extra_before_tail;
  endfunction

endpackage

// File: rtl/rs_hs_tail_ram.sv
// Simple dual-port storage for the tail FIFO: one write port, one registered read port.
module rs_hs_tail_ram
  import rs_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 49,
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_STYLE  = 0
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_rd_data;
  assign o_rd_data = r_rd_data;

  // Read data holds when i_rd_en is low; the top relies on that to keep of_data stable.
  generate
    if (MEM_STYLE == int'(MEM_BLOCK)) begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end else if (MEM_STYLE == int'(MEM_DIST)) begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end else begin : g_reg
      (* ram_style = "registers" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// Tail of the relay-station pipeline: absorbs non-stallable in-flight beats and
// re-presents them with a full valid/ready handshake, driving registered ready upstream.
module rs_hs_pipeline_tail_fifo
  import rs_hs_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 24,
  parameter int GRACE_PERIOD    = 21,
  parameter int REAL_DEPTH      = GRACE_PERIOD + DEPTH + REAL_DEPTH_PAD,
  parameter int REAL_ADDR_WIDTH = clog2(REAL_DEPTH),
  parameter int MEM_STYLE       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  input  logic [DATA_WIDTH-1:0]      if_data,
  output logic                       if_ready,
  output logic                       of_valid,
  output logic [DATA_WIDTH-1:0]      of_data,
  input  logic                       of_ready,
  output logic [REAL_ADDR_WIDTH:0]   occupancy,
  output logic                       overflow
);

  localparam int OW = REAL_ADDR_WIDTH + 1;
  localparam logic [OW-1:0]              C_DEPTH = OW'(DEPTH);
  localparam logic [OW-1:0]              C_FULL  = OW'(REAL_DEPTH);
  localparam logic [REAL_ADDR_WIDTH-1:0] C_LAST  = REAL_ADDR_WIDTH'(REAL_DEPTH - 1);

  logic [REAL_ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]              r_occ;
  logic                       r_of_valid, r_sel_ram, r_if_ready, r_overflow;
  logic [DATA_WIDTH-1:0]      r_byp_data;

  logic [DATA_WIDTH-1:0] w_ram_rd_data;
  logic [OW-1:0]         w_ram_cnt, w_occ_next;
  logic w_pop, w_full, w_out_free, w_ram_empty, w_wr_acc, w_bypass, w_ram_wr, w_refill;

  assign w_pop       = r_of_valid & of_ready;
  assign w_full      = (r_occ == C_FULL);
  assign w_out_free  = ~r_of_valid | w_pop;
  // Occupancy counts the output register too, so the RAM holds the remainder.
  assign w_ram_cnt   = r_occ - OW'(r_of_valid);
  assign w_ram_empty = (w_ram_cnt == '0);
  assign w_wr_acc    = if_valid & (~w_full | w_pop);
  assign w_bypass    = w_wr_acc & w_ram_empty & w_out_free;
  assign w_ram_wr    = w_wr_acc & ~w_bypass;
  assign w_refill    = w_out_free & ~w_ram_empty;
  assign w_occ_next  = r_occ + OW'(w_wr_acc) - OW'(w_pop);

  rs_hs_tail_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (REAL_DEPTH),
    .ADDR_WIDTH (REAL_ADDR_WIDTH),
    .MEM_STYLE  (MEM_STYLE)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_ram_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (if_data),
    .i_rd_en   (w_refill),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_of_valid <= 1'b0;
      r_sel_ram  <= 1'b0;
      r_byp_data <= '0;
      r_if_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ram_wr) r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_refill) r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
      r_occ      <= w_occ_next;
      r_of_valid <= w_refill | w_bypass | (r_of_valid & ~w_pop);
      // The RAM read register doubles as the output register on the normal path.
      if (w_bypass) begin
        r_sel_ram  <= 1'b0;
        r_byp_data <= if_data;
      end else if (w_refill) begin
        r_sel_ram  <= 1'b1;
      end
      r_if_ready <= (w_occ_next < C_DEPTH);
      if (if_valid & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  assign if_ready  = r_if_ready;
  assign of_valid  = r_of_valid;
  assign of_data   = r_sel_ram ? w_ram_rd_data : r_byp_data;
  assign occupancy = r_occ;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
// Self-checking bench for the pipeline tail FIFO: queue-based reference model plus
// a negedge monitor comparing every output against it.
module tb_rs_hs_pipeline_tail_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int REAL  = 49;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_valid = 1'b0;
  logic [DW-1:0] if_data = '0;
  logic          of_ready = 1'b0;
  logic          if_ready, of_valid, overflow;
  logic [DW-1:0] of_data;
  logic [6:0]    occupancy;

  rs_hs_pipeline_tail_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_data   (if_data),
    .if_ready  (if_ready),
    .of_valid  (of_valid),
    .of_data   (of_data),
    .of_ready  (of_ready),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue of held beats with a capacity of REAL.
  logic [DW-1:0] q_exp[$];
  int  m_cnt = 0;
  bit  m_ready = 1'b0;
  bit  m_ovf = 1'b0;
  bit  m_pop, m_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_exp.delete();
      m_cnt   = 0;
      m_ready = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_pop = (m_cnt > 0) && of_ready;
      m_acc = if_valid && ((m_cnt < REAL) || m_pop);
      if (m_acc) q_exp.push_back(if_data);
      else if (if_valid) m_ovf = 1'b1;
      m_cnt   = m_cnt + int'(m_acc) - int'(m_pop);
      m_ready = (m_cnt < DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("of_valid", 32'(of_valid), 32'(m_cnt > 0));
    chk("occupancy", 32'(occupancy), 32'(m_cnt));
    chk("if_ready", 32'(if_ready), 32'(m_ready));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (!reset) chk("of_data_in_reset", of_data, 32'h0);
    if (m_cnt > 0) begin
      if (q_exp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got of_data 0x%0h expected no beat at %0t", of_data, $time);
      end else if (of_ready) begin
        chk("of_data_pop", of_data, q_exp.pop_front());
      end else begin
        chk("of_data_hold", of_data, q_exp[0]);
      end
    end
  end

  logic [31:0] seq = 32'h1000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n);
    if_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if_data = seq;
      seq++;
      tick();
    end
    if_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    if_valid = 1'b0;
    of_ready = 1'b1;
    while (m_cnt > 0 && g < 300) begin
      tick();
      g++;
    end
    tick();
    chk("drain_occupancy", 32'(occupancy), 32'h0);
    chk("drain_of_valid", 32'(of_valid), 32'h0);
    of_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int g;
    logic [31:0] last_beat;

    // T1 reset
    repeat (5) begin
      tick();
      chk("t1_of_valid", 32'(of_valid), 32'h0);
      chk("t1_if_ready", 32'(if_ready), 32'h0);
      chk("t1_of_data", of_data, 32'h0);
    end
    reset = 1'b1;
    tick();
    chk("t1_if_ready_rise", 32'(if_ready), 32'h1);
    chk("t1_occupancy", 32'(occupancy), 32'h0);

    // T2 bypass
    of_ready = 1'b1;
    if_valid = 1'b1;
    if_data  = 32'hA5A5_0001;
    tick();
    if_valid = 1'b0;
    chk("t2_of_valid", 32'(of_valid), 32'h1);
    chk("t2_of_data", of_data, 32'hA5A5_0001);
    tick();
    chk("t2_occupancy", 32'(occupancy), 32'h0);
    of_ready = 1'b0;

    // T3 backpressure and grace
    if_valid = 1'b1;
    g = 0;
    do begin
      if_data = seq;
      seq++;
      tick();
      g++;
    end while (if_ready && g < 100);
    if_valid = 1'b0;
    chk("t3_ready_timeout", 32'(g < 100), 32'h1);
    chk("t3_occ_at_drop", 32'(occupancy), 32'd24);
    write_n(21);
    chk("t3_occ_after_grace", 32'(occupancy), 32'd45);
    chk("t3_overflow", 32'(overflow), 32'h0);
    drain();

    // T5 full with simultaneous write and pop
    write_n(49);
    chk("t5_occ_full", 32'(occupancy), 32'd49);
    if_valid = 1'b1;
    of_ready = 1'b1;
    if_data  = seq;
    seq++;
    tick();
    if_valid = 1'b0;
    of_ready = 1'b0;
    chk("t5_occ_stays", 32'(occupancy), 32'd49);
    chk("t5_overflow", 32'(overflow), 32'h0);
    drain();

    // T4 overflow
    write_n(49);
    if_valid  = 1'b1;
    last_beat = 32'hDEAD_BEEF;
    if_data   = last_beat;
    tick();
    if_valid = 1'b0;
    chk("t4_occ_sat", 32'(occupancy), 32'd49);
    chk("t4_overflow", 32'(overflow), 32'h1);
    drain();
    chk("t4_overflow_sticky", 32'(overflow), 32'h1);

    // T6 async reset mid-burst
    do_reset();
    write_n(30);
    chk("t6_occ", 32'(occupancy), 32'd30);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_of_valid_async", 32'(of_valid), 32'h0);
    chk("t6_occ_async", 32'(occupancy), 32'h0);
    chk("t6_of_data_async", of_data, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    of_ready = 1'b1;
    if_valid = 1'b1;
    if_data  = 32'hF00D_0001;
    tick();
    if_valid = 1'b0;
    chk("t6_fresh_valid", 32'(of_valid), 32'h1);
    chk("t6_fresh_data", of_data, 32'hF00D_0001);
    drain();

    // Random traffic respecting backpressure (grace never exceeded)
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if_valid = if_ready && ($urandom_range(0, 3) != 0);
      if_data  = $urandom;
      of_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    if_valid = 1'b0;
    drain();
    chk("rand_no_overflow", 32'(overflow), 32'h0);

    // Random traffic ignoring backpressure, exercising full and overflow
    for (int i = 0; i < 1500; i++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_data  = $urandom;
      of_ready = ($urandom_range(0, 9) < 4);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
